// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA constants and PC-target helpers for the PIC16F fetch path.
package instr_fetch_unit_pkg;

    localparam logic [13:0] ISA_NOP      = 14'h0000;
    localparam logic [12:0] RESET_VECTOR = 13'h0000;

    // goto/call literal field and the PCLATH bits that extend it
    localparam int K_MSB     = 10;
    localparam int K_LSB     = 0;
    localparam int PCLATH_HI = 4;
    localparam int PCLATH_LO = 3;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INCR,
        PC_PCL,
        PC_RET,
        PC_JUMP
    } pc_src_e;

    function automatic logic [12:0] goto_target(input logic [4:0] pclath, input logic [13:0] ir);
        return {pclath[PCLATH_HI:PCLATH_LO], ir[K_MSB:K_LSB]};
    endfunction

    function automatic logic [12:0] pcl_target(input logic [4:0] pclath, input logic [7:0] data);
        return {pclath, data};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_hw_return_stack.sv
// Circular hardware return stack with saturating occupancy count and sticky
// overflow/underflow flags. Contents are not reset; only pointer and count are.
module hw_return_stack #(
    parameter int STACK_DEPTH = 8,
    parameter int DATA_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              ovf,
    output logic              unf
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(STACK_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              ovf_q, unf_q;

    // ptr_q points at the next free slot; the top is the slot below it
    assign top_data = mem_q[ptr_q - PTR_ONE];
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_ONE;
            if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
            else                   cnt_q <= cnt_q + CNT_ONE;
        end else if (pop) begin
            ptr_q <= ptr_q - PTR_ONE;
            if (cnt_q == '0) unf_q <= 1'b1;
            else             cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PIC16F program counter, instruction register and return-stack front end;
// responds to the decoder's fetch-control strobes.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_rd_en,
    input  logic            instr_flush,
    input  logic            pc_incr_en,
    input  logic            pc_j_en,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic            pcl_wr_en,
    input  logic [7:0]      pcl_wr_data,
    input  logic [4:0]      pclath,
    input  logic [13:0]     prog_data,
    output logic [PC_W-1:0] prog_addr,
    output logic [13:0]     instr_current,
    output logic [7:0]      pcl,
    output logic            stack_ovf,
    output logic            stack_unf
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [13:0]     ir_q, ir_d;
    logic [PC_W-1:0] stk_top;
    pc_src_e         pc_src;
    logic            do_pop;

    hw_return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .DATA_W      (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (call_en),
        .pop       (do_pop),
        .push_data (pc_q),
        .top_data  (stk_top),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

    // Only pop when the return actually wins the PC mux
    assign do_pop = (pc_src == PC_RET);

    always_comb begin
        pc_src = PC_HOLD;
        if (pc_j_en || call_en)            pc_src = PC_JUMP;
        else if (ret_en)                   pc_src = PC_RET;
        else if (pcl_wr_en)                pc_src = PC_PCL;
        else if (pc_incr_en || instr_rd_en) pc_src = PC_INCR;
    end

    always_comb begin
        pc_d = pc_q;
        unique case (pc_src)
            PC_JUMP: pc_d = PC_W'(goto_target(pclath, ir_q));
            PC_RET:  pc_d = stk_top;
            PC_PCL:  pc_d = PC_W'(pcl_target(pclath, pcl_wr_data));
            PC_INCR: pc_d = pc_q + PC_W'(1);
            default: pc_d = pc_q;
        endcase
    end

    always_comb begin
        ir_d = ir_q;
        if (instr_flush)      ir_d = ISA_NOP;
        else if (instr_rd_en) ir_d = prog_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_W'(RESET_VECTOR);
            ir_q <= ISA_NOP;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign prog_addr     = pc_q;
    assign instr_current = ir_q;
    assign pcl           = pc_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, instr_rd_en, instr_flush, pc_incr_en, pc_j_en, call_en, ret_en, pcl_wr_en;
    logic [7:0]  pcl_wr_data;
    logic [4:0]  pclath;
    logic [13:0] prog_data;
    logic [12:0] prog_addr;
    logic [13:0] instr_current;
    logic [7:0]  pcl;
    logic        stack_ovf, stack_unf;

    logic [13:0] mem [8192];
    assign prog_data = mem[prog_addr];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
        .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .call_en(call_en), .ret_en(ret_en),
        .pcl_wr_en(pcl_wr_en), .pcl_wr_data(pcl_wr_data), .pclath(pclath),
        .prog_data(prog_data), .prog_addr(prog_addr), .instr_current(instr_current),
        .pcl(pcl), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    int errors = 0;
    int checks = 0;

    // reference state: stack is a ring of 8 slots indexed by an unbounded depth counter
    logic [12:0] m_pc;
    logic [13:0] m_ir;
    logic [12:0] m_stk [8];
    int          m_sp, m_cnt;
    logic        m_ovf, m_unf;

    localparam int OP_IDLE = 0, OP_FETCH = 1, OP_SKIP = 2, OP_GOTO = 3,
                   OP_CALL = 4, OP_RET = 5, OP_PCLW = 6, OP_RST = 7;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        rst = 0; instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0;
        pc_j_en = 0; call_en = 0; ret_en = 0; pcl_wr_en = 0;
    endtask

    task automatic model_step();
        logic [12:0] npc;
        logic [13:0] nir;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        nir = instr_flush ? 14'h0000 : (instr_rd_en ? mem[m_pc] : m_ir);
        npc = m_pc;
        if (pc_j_en || call_en) begin
            npc = {pclath[4:3], m_ir[10:0]};
            if (call_en) begin
                m_stk[m_sp & 7] = m_pc;
                m_sp++;
                if (m_cnt == 8) m_ovf = 1; else m_cnt++;
            end
        end else if (ret_en) begin
            m_sp--;
            npc = m_stk[m_sp & 7];
            if (m_cnt == 0) m_unf = 1; else m_cnt--;
        end else if (pcl_wr_en) begin
            npc = {pclath, pcl_wr_data};
        end else if (pc_incr_en || instr_rd_en) begin
            npc = m_pc + 13'd1;
        end
        m_pc = npc;
        m_ir = nir;
    endtask

    // apply the currently driven inputs for one clock and compare all outputs
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("prog_addr", {3'b0, prog_addr}, {3'b0, m_pc});
        chk("instr_current", {2'b0, instr_current}, {2'b0, m_ir});
        chk("pcl", {8'b0, pcl}, {8'b0, m_pc[7:0]});
        chk("flags", {14'b0, stack_ovf, stack_unf}, {14'b0, m_ovf, m_unf});
        clear_in();
    endtask

    task automatic do_op(input int op, input logic [4:0] lath, input logic [7:0] wd);
        clear_in();
        pclath = lath; pcl_wr_data = wd;
        case (op)
            OP_FETCH: begin instr_rd_en = 1; pc_incr_en = 1; end
            OP_SKIP:  begin instr_flush = 1; pc_incr_en = 1; end
            OP_GOTO:  begin instr_flush = 1; pc_j_en = 1; end
            OP_CALL:  begin instr_flush = 1; call_en = 1; end
            OP_RET:   begin instr_flush = 1; ret_en = 1; end
            OP_PCLW:  begin instr_flush = 1; pcl_wr_en = 1; end
            OP_RST:   rst = 1;
            default:  ;
        endcase
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 14'($urandom);
        mem[0] = 14'h3055; mem[1] = 14'h2805;
        mem[10] = 14'h1111; mem[11] = 14'h2222;
        clear_in(); pclath = 0; pcl_wr_data = 0;
        m_pc = 'x; m_ir = 'x;

        // reset and the first fetch of the reset vector
        do_op(OP_RST, 0, 0);
        do_op(OP_RST, 0, 0);
        chk("reset_pc", {3'b0, prog_addr}, 16'h0000);
        chk("reset_ir", {2'b0, instr_current}, 16'h0000);
        do_op(OP_IDLE, 0, 0);
        do_op(OP_IDLE, 0, 0);
        do_op(OP_FETCH, 0, 0);
        chk("vector_ir", {2'b0, instr_current}, 16'h3055);
        chk("vector_pc", {3'b0, prog_addr}, 16'h0001);

        // goto with PCLATH page bits
        do_op(OP_FETCH, 0, 0);
        chk("goto_ir_load", {2'b0, instr_current}, 16'h2805);
        do_op(OP_GOTO, 5'b11000, 0);
        chk("goto_pc", {3'b0, prog_addr}, 16'h1805);
        chk("goto_nop", {2'b0, instr_current}, 16'h0000);
        do_op(OP_FETCH, 0, 0);
        chk("goto_target_ir", {2'b0, instr_current}, {2'b0, mem[13'h1805]});
        chk("goto_next_pc", {3'b0, prog_addr}, 16'h1806);

        // skip at PC=10
        do_op(OP_PCLW, 0, 8'd10);
        do_op(OP_SKIP, 0, 0);
        chk("skip_pc", {3'b0, prog_addr}, 16'd11);
        do_op(OP_FETCH, 0, 0);
        chk("skip_ir", {2'b0, instr_current}, 16'h2222);

        // nine calls overflow the 8-entry stack, then unwind past empty
        do_op(OP_RST, 0, 0);
        for (int p = 1; p <= 9; p++) begin
            do_op(OP_PCLW, 0, 8'(p));
            do_op(OP_CALL, 0, 0);
            if (p == 8) chk("ovf_at_8", {15'b0, stack_ovf}, 16'h0000);
        end
        chk("ovf_at_9", {15'b0, stack_ovf}, 16'h0001);
        for (int r = 1; r <= 10; r++) begin
            do_op(OP_RET, 0, 0);
            if (r <= 8) chk("ret_value", {3'b0, prog_addr}, 16'(10 - r));
            if (r == 8) chk("unf_after_8", {15'b0, stack_unf}, 16'h0000);
            if (r == 9) chk("ret_wrapped", {3'b0, prog_addr}, 16'd9);
        end
        chk("unf_after_10", {15'b0, stack_unf}, 16'h0001);

        // PC wrap and PCL write
        do_op(OP_PCLW, 5'h1F, 8'hFF);
        do_op(OP_FETCH, 0, 0);
        chk("pc_wrap", {3'b0, prog_addr}, 16'h0000);
        do_op(OP_PCLW, 5'h03, 8'hA4);
        chk("pcl_write_pc", {3'b0, prog_addr}, 16'h03A4);
        chk("pcl_read", {8'b0, pcl}, 16'h00A4);

        // call immediately followed by return
        do_op(OP_PCLW, 0, 8'h40);
        do_op(OP_CALL, 5'b01000, 0);
        do_op(OP_RET, 0, 0);
        chk("call_ret", {3'b0, prog_addr}, 16'h0040);

        // reset right after a call discards the stack
        do_op(OP_RST, 0, 0);
        do_op(OP_PCLW, 0, 8'h05);
        do_op(OP_CALL, 0, 0);
        do_op(OP_RST, 0, 0);
        chk("rst_call_pc", {3'b0, prog_addr}, 16'h0000);
        chk("rst_call_ir", {2'b0, instr_current}, 16'h0000);
        do_op(OP_RET, 0, 0);
        chk("rst_call_unf", {15'b0, stack_unf}, 16'h0001);

        // PC-source priority: jump beats return, PCL write and increment
        do_op(OP_RST, 0, 0);
        do_op(OP_FETCH, 0, 0);
        clear_in();
        pclath = 5'b01000; pcl_wr_data = 8'h77;
        pc_j_en = 1; ret_en = 1; pcl_wr_en = 1; pc_incr_en = 1;
        tick();
        chk("prio_jump", {3'b0, prog_addr}, {3'b0, 2'b01, 11'h055});

        // randomized legal op stream
        do_op(OP_RST, 0, 0);
        for (int n = 0; n < 600; n++) begin
            int op;
            op = ($urandom_range(0, 99) == 0) ? OP_RST : int'($urandom_range(0, 6));
            do_op(op, 5'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
